// File: rtl/display_scan_mux_pkg.sv
// display_pkg: shared widths, constants, scan states and index-width helper
// for the multiplexed segment display.
package display_pkg;
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
    localparam logic [31:0] RESULT_BAD_IDX = 32'hFFFF_FFFF;

    typedef enum logic {SCAN_BLANK, SCAN_ON} scan_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/display_scan_mux_scan_timer.sv
// scan_timer: slot counter and digit index; phase_on marks the lit part of a slot.
module scan_timer
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    localparam int IDX_W = idx_w(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             phase_on,
    output logic [IDX_W-1:0] idx
);
    localparam int CNT_W = idx_w(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    scan_state_t      state;

    assign cnt_nxt  = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    assign phase_on = (state == SCAN_ON);

    // state is derived from the next count so it always matches cnt
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            state <= SCAN_BLANK;
        end else begin
            cnt   <= cnt_nxt;
            state <= (cnt_nxt >= CNT_ON) ? SCAN_ON : SCAN_BLANK;
            if (cnt == CNT_LAST)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: per-digit pattern store written via a custom-instruction
// port, time-multiplexed onto a shared segment bus with blanking gaps.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [31:0]           dataa,
    input  logic [31:0]           datab,
    output logic                  done,
    output logic [31:0]           result,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] dig_sel,
    input  logic                  blank
);
    localparam int IDX_W = idx_w(NUM_DIGITS);

    logic [SEG_W-1:0] pat [NUM_DIGITS];
    logic [IDX_W-1:0] idx, wr_idx;
    logic             phase_on, hit, show, unused_datab;

    assign wr_idx       = dataa[IDX_W-1:0];
    assign hit          = dataa < 32'(NUM_DIGITS);
    assign show         = phase_on && !blank;
    assign unused_datab = ^datab[31:SEG_W];

    scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .phase_on(phase_on),
        .idx     (idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            result  <= '0;
            seg     <= SEG_BLANK;
            dig_sel <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) pat[i] <= SEG_BLANK;
        end else begin
            done    <= en;
            result  <= !en ? '0 : hit ? 32'(pat[wr_idx]) : RESULT_BAD_IDX;
            if (en && hit) pat[wr_idx] <= datab[SEG_W-1:0];
            seg     <= show ? pat[idx] : SEG_BLANK;
            dig_sel <= show ? NUM_DIGITS'(1) << idx : '0;
        end
    end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: randomized and directed checks against a time-based
// reference model of the scanned display.
module tb_display_scan_mux;
    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        reset, en, blank, done;
    logic [31:0] dataa, datab, result;
    logic [6:0]  seg;
    logic [N-1:0] dig_sel;

    int errors = 0;
    int checks = 0;

    // model: cycles since reset, stored patterns, expected outputs
    int          tm;
    logic [6:0]  mpat [N];
    logic [6:0]  exp_seg;
    logic [N-1:0] exp_sel;
    logic        exp_done;
    logic [31:0] exp_res;

    display_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .reset(reset), .en(en), .dataa(dataa), .datab(datab),
        .done(done), .result(result), .seg(seg), .dig_sel(dig_sel), .blank(blank)
    );

    always #5 clk = ~clk;

    task automatic step();
        int d;
        bit on;
        @(posedge clk);
        if (reset) begin
            tm = 0;
            for (int i = 0; i < N; i++) mpat[i] = 7'h00;
            exp_seg = '0; exp_sel = '0; exp_done = 1'b0; exp_res = '0;
        end else begin
            d  = (tm / RD) % N;
            on = ((tm % RD) >= BL) && !blank;
            exp_sel  = on ? N'(1 << d) : '0;
            exp_seg  = on ? mpat[d] : 7'h00;
            exp_done = en;
            if (en) begin
                if (dataa < N) begin
                    exp_res = {25'b0, mpat[dataa]};
                    mpat[dataa] = datab[6:0];
                end else exp_res = 32'hFFFF_FFFF;
            end
            tm++;
        end
        #1;
    endtask

    task automatic wait_sel(input logic [N-1:0] target);
        int k = 0;
        while (dig_sel !== target && k < 4 * N * RD) begin
            step();
            k++;
        end
        if (dig_sel !== target) begin
            checks++; errors++;
            $display("FAIL wait_sel timeout: dig_sel=%b target=%b", dig_sel, target);
        end
    endtask

    task automatic test_reset();
        reset = 1; en = 0; blank = 0; dataa = 0; datab = 0;
        step(); step();
        checks++;
        if ({seg, dig_sel, done, result} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: seg=%h sel=%b done=%b result=%h want all 0", seg, dig_sel, done, result);
        end
        reset = 0;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 2 * N * RD + 6; i++) begin
            step();
            checks++;
            if (dig_sel !== exp_sel || seg !== exp_seg) begin
                errors++;
                $display("FAIL scan_idle cyc %0d: sel=%b seg=%h want sel=%b seg=%h", i, dig_sel, seg, exp_sel, exp_seg);
            end
            if (i == 1 || i == 2) begin
                checks++;
                if (dig_sel !== (i == 2 ? 4'b0001 : 4'b0000)) begin
                    errors++;
                    $display("FAIL scan_first_digit cyc %0d: sel=%b", i, dig_sel);
                end
            end
            checks++;
            if ($countones(dig_sel) > 1 || (dig_sel == '0 && seg != '0)) begin
                errors++;
                $display("FAIL scan_invariant: sel=%b seg=%h", dig_sel, seg);
            end
        end
    endtask

    task automatic test_write();
        en = 1; dataa = 2; datab = ($urandom & 32'hFFFF_FF80) | 32'h6D;
        step();
        en = 0;
        checks++;
        if (done !== 1'b1 || result !== exp_res || result !== 32'h0) begin
            errors++;
            $display("FAIL write_first: done=%b result=%h want done=1 result=%h", done, result, exp_res);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL write_done_pulse: done=%b want 0", done);
        end
        wait_sel(4'b0100);
        checks++;
        if (seg !== 7'h6D || seg !== exp_seg) begin
            errors++;
            $display("FAIL write_show: seg=%h want %h", seg, exp_seg);
        end
        en = 1; dataa = 2; datab = 32'h30;
        step();
        en = 0;
        checks++;
        if (done !== 1'b1 || result !== 32'h0000_006D || seg !== 7'h6D) begin
            errors++;
            $display("FAIL rewrite_edge: done=%b result=%h seg=%h want 1/0000006d/6d", done, result, seg);
        end
        step();
        checks++;
        if (seg !== 7'h30 || dig_sel !== 4'b0100 || seg !== exp_seg) begin
            errors++;
            $display("FAIL rewrite_show: seg=%h sel=%b want 30/0100", seg, dig_sel);
        end
    endtask

    task automatic test_bad_idx();
        logic [31:0] bad [2] = '{32'd7, 32'h0000_0102};
        for (int j = 0; j < 2; j++) begin
            en = 1; dataa = bad[j]; datab = 32'h7F;
            step();
            en = 0;
            checks++;
            if (done !== 1'b1 || result !== 32'hFFFF_FFFF || result !== exp_res) begin
                errors++;
                $display("FAIL bad_idx %h: done=%b result=%h want 1/ffffffff", bad[j], done, result);
            end
        end
        for (int i = 0; i < N * RD; i++) begin
            step();
            checks++;
            if (dig_sel !== exp_sel || seg !== exp_seg) begin
                errors++;
                $display("FAIL bad_idx_scan cyc %0d: sel=%b seg=%h want sel=%b seg=%h", i, dig_sel, seg, exp_sel, exp_seg);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ids [3] = '{0, 1, 3};
        en = 1;
        for (int j = 0; j < 3; j++) begin
            dataa = ids[j]; datab = $urandom;
            step();
            checks++;
            if (done !== 1'b1 || result !== exp_res || result !== 32'h0) begin
                errors++;
                $display("FAIL b2b write %0d: done=%b result=%h want 1/%h", ids[j], done, result, exp_res);
            end
        end
        en = 0;
        for (int i = 0; i < N * RD + 2; i++) begin
            step();
            checks++;
            if (done !== exp_done || dig_sel !== exp_sel || seg !== exp_seg) begin
                errors++;
                $display("FAIL b2b_scan cyc %0d: done=%b sel=%b seg=%h want %b/%b/%h", i, done, dig_sel, seg, exp_done, exp_sel, exp_seg);
            end
        end
    endtask

    task automatic test_blank();
        wait_sel(4'b0010);
        step();
        blank = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (dig_sel !== 4'b0 || seg !== 7'h0 || dig_sel !== exp_sel) begin
                errors++;
                $display("FAIL blank cyc %0d: sel=%b seg=%h want 0", i, dig_sel, seg);
            end
        end
        blank = 0;
        for (int i = 0; i < 2 * RD + 4; i++) begin
            step();
            checks++;
            if (dig_sel !== exp_sel || seg !== exp_seg) begin
                errors++;
                $display("FAIL blank_resume cyc %0d: sel=%b seg=%h want sel=%b seg=%h", i, dig_sel, seg, exp_sel, exp_seg);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            en    = ($urandom_range(0, 2) == 0);
            dataa = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 5);
            datab = $urandom;
            blank = ($urandom_range(0, 9) == 0);
            step();
            checks++;
            if (done !== exp_done || dig_sel !== exp_sel || seg !== exp_seg ||
                (exp_done && result !== exp_res)) begin
                errors++;
                $display("FAIL random cyc %0d: done=%b res=%h sel=%b seg=%h want %b/%h/%b/%h",
                         i, done, result, dig_sel, seg, exp_done, exp_res, exp_sel, exp_seg);
            end
        end
        en = 0; blank = 0;
    endtask

    task automatic test_reset_mid();
        wait_sel(4'b0010);
        reset = 1; en = 1; dataa = 1; datab = 32'h7F;
        step();
        reset = 0; en = 0;
        checks++;
        if ({seg, dig_sel, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid: seg=%h sel=%b done=%b want 0", seg, dig_sel, done);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_done: done=%b want 0", done);
        end
        wait_sel(4'b0010);
        checks++;
        if (seg !== 7'h00 || seg !== exp_seg) begin
            errors++;
            $display("FAIL reset_mid_pattern: seg=%h want 00", seg);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write();
        test_bad_idx();
        test_back_to_back();
        test_blank();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
